rv32_bram_lsu: RTL and testbench
================================

// Module: rv32_bram_lsu
// PURPOSE
//  Load/store client for the single-clock block-RAM data memory. Accepts byte/half/word
//  requests from the multicycle core on a valid/ready channel and drives the BRAM's
//  write port (wen/waddr/wdata) and registered read port (ren/raddr/rdata, 1-cycle latency).
//  Sub-word stores use read-modify-write (the BRAM has no byte enables). Loads are sign/zero-extended.
// PARAMETERS
//  ADDR_SIZE  8   BRAM word-address width; memory spans 4*2**ADDR_SIZE bytes
// PORTS
//  clk          in   1          single clock; BRAM wclk and rclk both tie to it
//  rst_n        in   1          asynchronous, active-low reset
//  req_valid    in   1          request present
//  req_ready    out  1          1 only in IDLE
//  req_we       in   1          1=store, 0=load
//  req_size     in   2          00 byte, 01 half, 10 word (11 -> error)
//  req_unsigned in   1          load zero-extend (LBU/LHU); ignored for stores
//  req_addr     in   32         byte address
//  req_wdata    in   32         store data, right-justified
//  rsp_valid    out  1          response present; held until rsp_ready
//  rsp_ready    in   1          core accepts response
//  rsp_rdata    out  32         extended load data; 0 for stores and errors
//  rsp_err      out  1          misaligned / out-of-range / bad size
//  bram_wen     out  1          BRAM write enable
//  bram_waddr   out  ADDR_SIZE  BRAM write word address
//  bram_wdata   out  32         BRAM write data
//  bram_ren     out  1          BRAM read enable
//  bram_raddr   out  ADDR_SIZE  BRAM read word address
//  bram_rdata   in   32         BRAM read data, valid the cycle after bram_ren
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; rsp_valid, rsp_err, bram_wen, bram_ren = 0;
//   rsp_rdata, bram_* addr/data = 0; latched request cleared. Reset mid-operation aborts
//   instantly; bram_wen drops asynchronously, so no partial RMW write is committed.
//  Handshake: request latched on req_valid&&req_ready; one request in flight; response
//   consumed on rsp_valid&&rsp_ready, then IDLE (req_ready=1 next cycle, no bubble-free accept).
//  Word address = req_addr[ADDR_SIZE+1:2]; lane = req_addr[1:0].
//  Error checks at accept: req_size==11, or req_addr[31:ADDR_SIZE+2]!=0, or misalignment
//   (see CONFIGURATION) -> IDLE->RESP, rsp_err=1, no BRAM access.
//  FSM states IDLE, READ, DATA, WRITE, RESP:
//   IDLE  -> READ on load or sub-word store; -> WRITE on word store; -> RESP on error.
//   READ  : bram_ren=1, bram_raddr=word addr; -> DATA.
//   DATA  : bram_rdata valid. Load: shift lane to bit 0, extend per size/unsigned, register
//           into rsp_rdata, -> RESP. Store: merge req_wdata byte/half into lane, -> WRITE.
//   WRITE : bram_wen=1 for exactly one cycle with merged (or full) word; -> RESP.
//   RESP  : rsp_valid=1, outputs stable until rsp_ready; -> IDLE.
//  Latency accept->rsp_valid: load 3 cycles; word store 2; sub-word store 4; error 1.
//  bram_wen and bram_ren never asserted in the same cycle. rsp_rdata=0 for stores.
// CONFIGURATION
//  RV32_LSU_MISALIGN_TRAP_EN defined: half with addr[0]!=0 or word with addr[1:0]!=0
//   -> rsp_err=1, no access.
//  Undefined: misaligned addresses silently aligned down (half: addr[0] forced 0; word:
//   addr[1:0] forced 0); size/range errors still reported.
// STRUCTURE
//  rv32_lsu_pkg: lsu_state_e {IDLE,READ,DATA,WRITE,RESP}; lsu_size_e {LSU_BYTE=2'b00,
//   LSU_HALF=2'b01,LSU_WORD=2'b10}; WORD_W=32 constant.
//  Sub-module rv32_lsu_align (combinational): load extract/extend and store lane merge;
//   top holds FSM, request latch, BRAM port drive.
// TESTING (bench instantiates the BRAM model beside the block)
//  1 word store 0xDEADBEEF @0x10, then word load @0x10 -> bram_wen 1 cycle, waddr=4;
//    load rsp_rdata=0xDEADBEEF, rsp_valid 3 cycles after accept, rsp_err=0.
//  2 SB 0x5A @0x13 over 0x11223344 -> READ, DATA, WRITE; bram_wdata=0x5A223344; LB @0x13
//    -> 0x0000005A; SB 0x80 @0x12 then LB @0x12 -> 0xFFFFFF80, LBU -> 0x00000080.
//  3 LH @0x11 with RV32_LSU_MISALIGN_TRAP_EN -> rsp_err=1 next cycle, no ren/wen;
//    without macro -> reads halfword at 0x10.
//  4 req_addr=0x0000_0400 (ADDR_SIZE=8) or req_size=11 -> rsp_err=1, rsp_rdata=0, no access.
//  5 hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 throughout.
//  6 assert rst_n=0 during WRITE of a sub-word store -> bram_wen=0 immediately, memory
//    word unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/rv32_lsu_pkg.sv
// Shared types for the BRAM load/store unit: FSM states, access sizes and the
// latched request payload.
package rv32_lsu_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DATA,
        WRITE,
        RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        LSU_BYTE = 2'b00,
        LSU_HALF = 2'b01,
        LSU_WORD = 2'b10
    } lsu_size_e;

    // Request fields kept across the multi-cycle access; word address lives in
    // the BRAM address registers, so only the byte lane is held here.
    typedef struct packed {
        logic              we;
        lsu_size_e         size;
        logic              uns;
        logic [1:0]        lane;
        logic [WORD_W-1:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/rv32_lsu_align.sv
// Combinational lane logic for the LSU.
//   rdata        : word read from BRAM
//   size/uns     : access size and zero-extend flag
//   lane         : byte offset within the word (already aligned for half/word)
//   wdata        : right-justified store data
//   load_data_c  : lane shifted to bit 0 and sign/zero-extended
//   merge_data_c : rdata with the store byte/half replaced (full wdata for word)
module rv32_lsu_align
    import rv32_lsu_pkg::*;
(
    input  logic [WORD_W-1:0] rdata,
    input  lsu_size_e         size,
    input  logic              uns,
    input  logic [1:0]        lane,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data_c,
    output logic [WORD_W-1:0] merge_data_c
);

    logic [4:0]        shamt;
    logic [WORD_W-1:0] shifted;
    logic [WORD_W-1:0] wdata_sh;
    logic [WORD_W-1:0] lane_mask;

    always_comb begin
        shamt       = {lane, 3'b000};
        shifted     = rdata >> shamt;
        wdata_sh    = wdata << shamt;
        load_data_c = shifted;
        lane_mask   = '1;
        case (size)
            LSU_BYTE: begin
                load_data_c = {{24{~uns & shifted[7]}}, shifted[7:0]};
                lane_mask   = 32'h0000_00FF << shamt;
            end
            LSU_HALF: begin
                load_data_c = {{16{~uns & shifted[15]}}, shifted[15:0]};
                lane_mask   = 32'h0000_FFFF << shamt;
            end
            default: begin
                load_data_c = shifted;
                lane_mask   = '1;
            end
        endcase
        merge_data_c = (rdata & ~lane_mask) | (wdata_sh & lane_mask);
    end

endmodule

// File: rtl/rv32_bram_lsu.sv
// Load/store client for a single-clock BRAM without byte enables.
// Sub-word stores use read-modify-write; loads are sign/zero-extended.
// Build option: RV32_LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses
// report rsp_err; otherwise they are silently aligned down.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_we/size/unsigned/addr/wdata : request payload
//   rsp_valid/rsp_ready        : response handshake, held until accepted
//   rsp_rdata/rsp_err          : extended load data / error flag
//   bram_wen/waddr/wdata       : BRAM write port
//   bram_ren/raddr/rdata       : BRAM read port, rdata valid one cycle after ren
module rv32_bram_lsu
    import rv32_lsu_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 bram_wen,
    output logic [ADDR_SIZE-1:0] bram_waddr,
    output logic [31:0]          bram_wdata,
    output logic                 bram_ren,
    output logic [ADDR_SIZE-1:0] bram_raddr,
    input  logic [31:0]          bram_rdata
);

    lsu_state_e            state_q, state_d;
    lsu_req_t              req_q, req_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  bram_wen_q, bram_wen_d;
    logic [ADDR_SIZE-1:0]  bram_waddr_q, bram_waddr_d;
    logic [WORD_W-1:0]     bram_wdata_q, bram_wdata_d;
    logic                  bram_ren_q, bram_ren_d;
    logic [ADDR_SIZE-1:0]  bram_raddr_q, bram_raddr_d;

    logic                  size_bad, range_bad, misalign, acc_err;
    logic [1:0]            lane_acc;
    logic [WORD_W-1:0]     load_data_c, merge_data_c;

    // Accept-time checks and lane selection.
    always_comb begin
        size_bad  = (req_size == 2'b11);
        range_bad = (req_addr[31:ADDR_SIZE+2] != '0);
        lane_acc  = req_addr[1:0];
        misalign  = 1'b0;
`ifdef RV32_LSU_MISALIGN_TRAP_EN
        misalign  = ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        if (req_size == 2'b01) begin
            lane_acc = {req_addr[1], 1'b0};
        end else if (req_size == 2'b10) begin
            lane_acc = 2'b00;
        end
`endif
        acc_err = size_bad | range_bad | misalign;
    end

    rv32_lsu_align u_align (
        .rdata        (bram_rdata),
        .size         (req_q.size),
        .uns          (req_q.uns),
        .lane         (req_q.lane),
        .wdata        (req_q.wdata),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        bram_wen_d   = 1'b0;
        bram_waddr_d = bram_waddr_q;
        bram_wdata_d = bram_wdata_q;
        bram_ren_d   = 1'b0;
        bram_raddr_d = bram_raddr_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (acc_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        req_d.we     = req_we;
                        req_d.size   = lsu_size_e'(req_size);
                        req_d.uns    = req_unsigned;
                        req_d.lane   = lane_acc;
                        req_d.wdata  = req_wdata;
                        bram_raddr_d = req_addr[ADDR_SIZE+1:2];
                        bram_waddr_d = req_addr[ADDR_SIZE+1:2];
                        if (req_we && (req_size == 2'b10)) begin
                            state_d      = WRITE;
                            bram_wen_d   = 1'b1;
                            bram_wdata_d = req_wdata;
                        end else begin
                            state_d    = READ;
                            bram_ren_d = 1'b1;
                        end
                    end
                end
            end
            READ: begin
                state_d = DATA;
            end
            DATA: begin
                if (req_q.we) begin
                    state_d      = WRITE;
                    bram_wen_d   = 1'b1;
                    bram_wdata_d = merge_data_c;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_data_c;
                end
            end
            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Async reset clears bram_wen immediately, so an interrupted RMW never commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            bram_wen_q   <= 1'b0;
            bram_waddr_q <= '0;
            bram_wdata_q <= '0;
            bram_ren_q   <= 1'b0;
            bram_raddr_q <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            bram_wen_q   <= bram_wen_d;
            bram_waddr_q <= bram_waddr_d;
            bram_wdata_q <= bram_wdata_d;
            bram_ren_q   <= bram_ren_d;
            bram_raddr_q <= bram_raddr_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign bram_wen   = bram_wen_q;
    assign bram_waddr = bram_waddr_q;
    assign bram_wdata = bram_wdata_q;
    assign bram_ren   = bram_ren_q;
    assign bram_raddr = bram_raddr_q;

endmodule

// File: tb/tb_rv32_bram_lsu.sv
// Self-checking bench for rv32_bram_lsu with a behavioural BRAM beside it.
module tb_rv32_bram_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bram_wen;
    logic [7:0]  bram_waddr;
    logic [31:0] bram_wdata;
    logic        bram_ren;
    logic [7:0]  bram_raddr;
    logic [31:0] bram_rdata;

    rv32_bram_lsu #(.ADDR_SIZE(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .bram_wen     (bram_wen),
        .bram_waddr   (bram_waddr),
        .bram_wdata   (bram_wdata),
        .bram_ren     (bram_ren),
        .bram_raddr   (bram_raddr),
        .bram_rdata   (bram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: synchronous write, registered read.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (bram_wen) mem[bram_waddr] <= bram_wdata;
        if (bram_ren) bram_rdata <= mem[bram_raddr];
    end

    // Port activity monitor, sampled mid-cycle.
    int          ren_tot  = 0;
    int          wen_tot  = 0;
    int          both_tot = 0;
    logic [31:0] last_wdata = '0;
    logic [7:0]  last_waddr = '0;
    always @(negedge clk) begin
        if (bram_ren) ren_tot++;
        if (bram_wen) begin
            wen_tot++;
            last_wdata = bram_wdata;
            last_waddr = bram_waddr;
        end
        if (bram_ren && bram_wen) both_tot++;
    end

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_ren;
        int          exp_wen;
        logic [31:0] exp_wdata;
        logic [7:0]  exp_waddr;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_lat, input int exp_ren, input int exp_wen,
                                input logic [31:0] exp_wdata, input logic [7:0] exp_waddr);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_ren = exp_ren; v.exp_wen = exp_wen; v.exp_wdata = exp_wdata;
        v.exp_waddr = exp_waddr;
        return v;
    endfunction

    // Present a request, wait (bounded) for rsp_valid; lat counts cycles after the accept cycle.
    task automatic issue(input vec_t v, output int lat, output int r0, output int w0);
        @(negedge clk);
        #1;
        r0 = ren_tot;
        w0 = wen_tot;
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        int lat, r0, w0;
        logic [31:0] rd;
        logic        er;
        vec_t        v;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

        //            we    sz     u     addr           wdata          rdata          err   lat ren wen wdata          waddr
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 0, 1, 32'hDEAD_BEEF, 8'h04));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 1, 0, 32'h0,         8'h00));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1122_3344, 32'h0,         1'b0, 2, 0, 1, 32'h1122_3344, 8'h04));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_005A, 32'h0,         1'b0, 4, 1, 1, 32'h5A22_3344, 8'h04));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_005A, 1'b0, 3, 1, 0, 32'h0,         8'h00));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0000_0012, 32'hFFFF_FF80, 32'h0,         1'b0, 4, 1, 1, 32'h5A80_3344, 8'h04));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0012, 32'h0,         32'hFFFF_FF80, 1'b0, 3, 1, 0, 32'h0,         8'h00));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_0080, 1'b0, 3, 1, 0, 32'h0,         8'h00));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_5A80, 1'b0, 3, 1, 0, 32'h0,         8'h00));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_3344, 1'b0, 3, 1, 0, 32'h0,         8'h00));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h1234_BEEF, 32'h0,         1'b0, 4, 1, 1, 32'hBEEF_3344, 8'h04));
        vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         32'h0000_BEEF, 1'b0, 3, 1, 0, 32'h0,         8'h00));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         32'hFFFF_BEEF, 1'b0, 3, 1, 0, 32'h0,         8'h00));
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_0033, 1'b0, 3, 1, 0, 32'h0,         8'h00));
`ifdef RV32_LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h0,         8'h00));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h0,         8'h00));
`else
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,         32'h0000_3344, 1'b0, 3, 1, 0, 32'h0,         8'h00));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0,         32'hBEEF_3344, 1'b0, 3, 1, 0, 32'h0,         8'h00));
`endif
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h0,         8'h00));
        vecs.push_back(mk(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 1, 0, 0, 32'h0,         8'h00));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h0000_FFFF, 32'h0,         1'b1, 1, 0, 0, 32'h0,         8'h00));
        vecs.push_back(mk(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h0000_FFFF, 32'h0,         1'b1, 1, 0, 0, 32'h0,         8'h00));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,         1'b0, 2, 0, 1, 32'hCAFE_F00D, 8'hFF));
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 1'b0, 3, 1, 0, 32'h0,         8'h00));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0000_03FF, 32'h0,         32'h0000_00CA, 1'b0, 3, 1, 0, 32'h0,         8'h00));

        // Reset state.
        #12;
        chk("reset req_ready", 32'(req_ready), 32'h1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset rsp_err",   32'(rsp_err),   32'h0);
        chk("reset rsp_rdata", rsp_rdata,      32'h0);
        chk("reset bram_wen",  32'(bram_wen),  32'h0);
        chk("reset bram_ren",  32'(bram_ren),  32'h0);
        chk("reset raddr",     32'(bram_raddr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            issue(v, lat, r0, w0);
            rd = rsp_rdata;
            er = rsp_err;
            chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'h1);
            chk($sformatf("v%0d rdata", i),   rd,          v.exp_rdata);
            chk($sformatf("v%0d err", i),     32'(er),     32'(v.exp_err));
            chk($sformatf("v%0d latency", i), 32'(lat),    32'(v.exp_lat));
            chk($sformatf("v%0d req_ready busy", i), 32'(req_ready), 32'h0);
            consume();
            chk($sformatf("v%0d req_ready after", i), 32'(req_ready), 32'h1);
            chk($sformatf("v%0d ren count", i), 32'(ren_tot - r0), 32'(v.exp_ren));
            chk($sformatf("v%0d wen count", i), 32'(wen_tot - w0), 32'(v.exp_wen));
            if (v.exp_wen != 0) begin
                chk($sformatf("v%0d wdata", i), last_wdata,       v.exp_wdata);
                chk($sformatf("v%0d waddr", i), 32'(last_waddr),  32'(v.exp_waddr));
            end
        end

        // Response held under back-pressure for 5 cycles.
        v = mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'hBEEF_3344, 1'b0, 3, 1, 0, 32'h0, 8'h00);
        issue(v, lat, r0, w0);
        chk("hold latency", 32'(lat), 32'h3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d rsp_valid", c), 32'(rsp_valid), 32'h1);
            chk($sformatf("hold%0d rsp_rdata", c), rsp_rdata,      32'hBEEF_3344);
            chk($sformatf("hold%0d req_ready", c), 32'(req_ready), 32'h0);
        end
        consume();
        chk("hold release rsp_valid", 32'(rsp_valid), 32'h0);

        // Reset asserted during the WRITE cycle of a sub-word store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0000_0010; req_wdata = 32'h0000_0077;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!bram_wen && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("rst-mid wen seen", 32'(bram_wen), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst-mid bram_wen", 32'(bram_wen),  32'h0);
        chk("rst-mid rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst-mid mem", mem[4], 32'hBEEF_3344);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst-mid req_ready", 32'(req_ready), 32'h1);
        v = mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'hBEEF_3344, 1'b0, 3, 1, 0, 32'h0, 8'h00);
        issue(v, lat, r0, w0);
        chk("post-rst rdata", rsp_rdata, 32'hBEEF_3344);
        chk("post-rst latency", 32'(lat), 32'h3);
        consume();

        chk("ren&wen overlap", 32'(both_tot), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
